reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 Parameter NREGS, default 32, number of architectural registers; address width is 5.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rs1_addr  input  5  read port 1 register index.
REQ-007 rs2_addr  input  5  read port 2 register index.
REQ-008 rs1_data  output  XLEN  read port 1 data, combinational.
REQ-009 rs2_data  output  XLEN  read port 2 data, combinational.
REQ-010 rs1_busy  output  1  rs1 has an outstanding write; consumer must stall.
REQ-011 rs2_busy  output  1  rs2 has an outstanding write; consumer must stall.
REQ-012 issue_valid  input  1  a multi-cycle instruction (load, etc.) claims issue_rd.
REQ-013 issue_rd  input  5  destination register being claimed.
REQ-014 issue_ready  output  1  claim accepted this cycle when issue_valid=1.
REQ-015 wb_valid  input  1  writeback of wb_data to wb_rd (selected rd value from writeback mux).
REQ-016 wb_rd  input  5  writeback destination index.
REQ-017 wb_data  input  XLEN  writeback value.
REQ-018 pending_count  output  6  number of registers currently marked busy.

Function
REQ-019 Storage: NREGS x XLEN registers plus one busy bit per register; x0 SHALL have no storage and no busy bit.
REQ-020 Write: on clk edge with rst=0, wb_valid=1 and wb_rd!=0, reg[wb_rd] SHALL take wb_data and busy[wb_rd] SHALL clear; wb_rd=0 ignored.
REQ-021 Writeback to a non-busy register SHALL be written normally (single-cycle ops are untracked); busy bits unaffected.
REQ-022 Read: rsN_addr=0 SHALL return 0 and rsN_busy=0.
REQ-023 Bypass: if wb_valid=1 and wb_rd==rsN_addr!=0, rsN_data SHALL equal wb_data and rsN_busy=0 in the same cycle.
REQ-024 Otherwise rsN_data=reg[rsN_addr], rsN_busy=busy[rsN_addr].
REQ-025 issue_ready SHALL be 1 when issue_rd=0, or busy[issue_rd]=0, or (wb_valid=1 and wb_rd==issue_rd); else 0 (WAW stall).
REQ-026 Claim: issue_valid=1 and issue_ready=1 and issue_rd!=0 SHALL set busy[issue_rd] on the next edge; issue_rd=0 accepted with no state change.
REQ-027 Simultaneous claim and writeback to the same register: write SHALL occur and busy SHALL end set (set wins over clear).
REQ-028 issue_ready SHALL not depend on issue_valid (no combinational loop).
REQ-029 pending_count SHALL be registered, updated each edge by +1 on claim, -1 on clear of a busy bit, unchanged when both or neither; range 0..31, never wraps.
REQ-030 Read latency 0 cycles; write and busy update latency 1 edge.

Reset
REQ-031 While rst=1 at an edge: all registers 0, all busy bits 0, pending_count 0; wb_valid and issue_valid SHALL be ignored that cycle.
REQ-032 Reset mid-operation SHALL discard all outstanding claims; a later writeback to a formerly busy register is treated as untracked (REQ-021).
REQ-033 After reset, rs1_data=rs2_data=0, rs1_busy=rs2_busy=0, issue_ready=1.

Verification
REQ-034 Write x5=0xDEADBEEF, next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF, rs1_busy=0.
REQ-035 wb_rd=0, wb_data=0x1234; read x0 -> 0; pending_count unchanged.
REQ-036 Claim x7; next cycle rs2_addr=7 -> rs2_busy=1, pending_count=1; second claim x7 -> issue_ready=0; wb x7=0x55 -> same cycle rs2_data=0x55, rs2_busy=0, issue_ready=1; next cycle pending_count=0.
REQ-037 x9 busy; same cycle claim x9 and wb x9=0xA5 -> after edge reg[9]=0xA5, busy[9]=1, pending_count unchanged.
REQ-038 Claim x3,x4,x6 on successive cycles, assert rst with wb_valid=1 wb_rd=3 -> after edge all regs 0, pending_count=0, rs1_busy=0 for x3.
REQ-039 Claim all 31 nonzero registers -> pending_count=31; write back all -> pending_count=0, no wrap.

Source files
------------

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with per-register busy scoreboard and writeback bypass
// x0 is hardwired to zero and never tracked; reads see same-cycle writeback.
module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [5:0]      pending_count
);

    logic [XLEN-1:0] regs [1:NREGS-1];
    logic [NREGS-1:1] busy;

    logic wb_write;
    logic claim;
    logic clear_busy;

    function automatic logic in_range(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NREGS);
    endfunction

    assign wb_write = wb_valid && in_range(wb_rd);

    // A claim on a busy register is allowed only when that register retires this same cycle.
    always_comb begin
        issue_ready = 1'b1;
        if (in_range(issue_rd) && busy[issue_rd] && !(wb_write && (wb_rd == issue_rd))) begin
            issue_ready = 1'b0;
        end
    end

    assign claim      = issue_valid && issue_ready && in_range(issue_rd);
    assign clear_busy = wb_write && busy[wb_rd];

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (in_range(rs1_addr)) begin
            if (wb_write && (wb_rd == rs1_addr)) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs[rs1_addr];
                rs1_busy = busy[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (in_range(rs2_addr)) begin
            if (wb_write && (wb_rd == rs2_addr)) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs[rs2_addr];
                rs2_busy = busy[rs2_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Set is scheduled after clear so a same-register claim and writeback leaves the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wb_write) begin
                busy[wb_rd] <= 1'b0;
            end
            if (claim) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_count <= '0;
        end else begin
            case ({claim, clear_busy})
                2'b10: if (pending_count != 6'd63) pending_count <= pending_count + 6'd1;
                2'b01: if (pending_count != 6'd0)  pending_count <= pending_count - 6'd1;
                default: pending_count <= pending_count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and randomized checks of reg_file_sb against a scoreboard model
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  pending_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    reg_file_sb #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int busy_total();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_valid && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (wb_valid && wb_rd == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        return (issue_rd == 0) || !m_busy[issue_rd] || (wb_valid && wb_rd == issue_rd);
    endfunction

    task automatic drive(input logic r, input logic iv, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst = r; issue_valid = iv; issue_rd = ird;
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
        rs1_addr = a1; rs2_addr = a2;
        #1;
    endtask

    // Compare combinational outputs, advance the model and the DUT one edge, then compare the counter.
    task automatic cycle();
        bit claim_ok;
        chk("rs1_data", rs1_data, exp_data(rs1_addr));
        chk("rs2_data", rs2_data, exp_data(rs2_addr));
        chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(rs1_addr)});
        chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(rs2_addr)});
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, exp_ready()});
        claim_ok = issue_valid && exp_ready() && issue_rd != 0;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb_valid && wb_rd != 0) begin
                m_regs[wb_rd] = wb_data;
                m_busy[wb_rd] = 1'b0;
            end
            if (claim_ok) m_busy[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("pending_count", {26'd0, pending_count}, busy_total());
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end

        // reset state
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 0, 5'd5, 0, 0, 0, 5'd1, 5'd2);
        chk("rst_rs1_data", rs1_data, 32'd0);
        chk("rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_pending", {26'd0, pending_count}, 32'd0);

        // plain write then read
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 5'd5, 0);
        chk("x5_read", rs1_data, 32'hDEADBEEF);
        chk("x5_busy", {31'd0, rs1_busy}, 32'd0);
        cycle();

        // x0 write ignored
        drive(0, 0, 0, 1, 5'd0, 32'h1234, 5'd0, 5'd0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        chk("x0_read", rs1_data, 32'd0);
        chk("x0_pending", {26'd0, pending_count}, 32'd0);
        cycle();

        // claim, WAW stall, bypassed retirement
        drive(0, 1, 5'd7, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 5'd7, 0, 0, 0, 0, 5'd7);
        chk("x7_busy", {31'd0, rs2_busy}, 32'd1);
        chk("x7_pending1", {26'd0, pending_count}, 32'd1);
        chk("x7_waw_stall", {31'd0, issue_ready}, 32'd0);
        cycle();
        drive(0, 0, 5'd7, 1, 5'd7, 32'h55, 0, 5'd7);
        chk("x7_bypass_data", rs2_data, 32'h55);
        chk("x7_bypass_busy", {31'd0, rs2_busy}, 32'd0);
        chk("x7_ready", {31'd0, issue_ready}, 32'd1);
        cycle();
        chk("x7_pending0", {26'd0, pending_count}, 32'd0);

        // claim and writeback same busy register: set wins
        drive(0, 1, 5'd9, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 5'd9, 1, 5'd9, 32'hA5, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 5'd9, 0);
        chk("x9_data", rs1_data, 32'hA5);
        chk("x9_busy", {31'd0, rs1_busy}, 32'd1);
        chk("x9_pending", {26'd0, pending_count}, 32'd1);
        cycle();
        drive(0, 0, 0, 1, 5'd9, 32'hA6, 0, 0);
        cycle();

        // reset discards outstanding claims and ignores writeback
        drive(0, 1, 5'd3, 0, 0, 0, 0, 0); cycle();
        drive(0, 1, 5'd4, 0, 0, 0, 0, 0); cycle();
        drive(0, 1, 5'd6, 0, 0, 0, 0, 0); cycle();
        drive(1, 1, 5'd8, 1, 5'd3, 32'hFFFF, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd5);
        chk("rst_x3_data", rs1_data, 32'd0);
        chk("rst_x3_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rst_x5_data", rs2_data, 32'd0);
        chk("rst_mid_pending", {26'd0, pending_count}, 32'd0);
        cycle();
        drive(0, 0, 0, 1, 5'd3, 32'h33, 0, 0); cycle();
        chk("untracked_pending", {26'd0, pending_count}, 32'd0);

        // fill and drain the scoreboard
        for (int r = 1; r < 32; r++) begin
            drive(0, 1, 5'(r), 0, 0, 0, 5'(r), 0);
            cycle();
        end
        chk("full_pending", {26'd0, pending_count}, 32'd31);
        for (int r = 1; r < 32; r++) begin
            drive(0, 0, 0, 1, 5'(r), 32'(r * 3), 0, 5'(r));
            cycle();
        end
        chk("drain_pending", {26'd0, pending_count}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0),
                  1'($urandom), 5'($urandom),
                  1'($urandom), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
